// File: rtl/dynamic_stepper_pkg.sv
// Shared types and sizing helpers for the button-driven inc/dec stepper.
package dynamic_stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Width able to hold the largest of the four cycle counts.
    function automatic int unsigned timer_width(int unsigned deb, int unsigned step_high,
                                                int unsigned rep_delay, int unsigned rep_period);
        int unsigned m;
        m = deb;
        if (step_high > m)  m = step_high;
        if (rep_delay > m)  m = rep_delay;
        if (rep_period > m) m = rep_period;
        return unsigned'($clog2(m + 1));
    endfunction

endpackage

// File: rtl/dynamic_stepper_debounce.sv
// Two-flop synchroniser plus stability counter for one raw push button.
module button_debounce
    import dynamic_stepper_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CW = timer_width(DEBOUNCE_CYCLES, 1, 1, 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [1:0]    vld_q, vld_d;
    logic          armed_q, armed_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ref_lvl;
    logic          differ;

    // Until armed, a button held through reset must first be seen released,
    // so the reference is forced high and only a stable low arms the input.
    assign ref_lvl = level_q | ~armed_q;
    assign differ  = vld_q[1] & (sync_q[1] != ref_lvl);

    always_comb begin
        sync_d  = {sync_q[0], btn_i};
        vld_d   = {vld_q[0], 1'b1};
        armed_d = armed_q;
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = cnt_q;
        if (!differ) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (armed_q) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                armed_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            vld_q   <= '0;
            armed_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            armed_q <= armed_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/dynamic_stepper.sv
// Turns up/down push buttons into single-step inc/dec pulses with auto-repeat.
//   state | meaning
//   IDLE  | no press latched, waiting for a clean rising edge
//   PULSE | inc or dec high for STEP_HIGH cycles
//   WAIT  | outputs low; first gap REPEAT_DELAY, later gaps REPEAT_PERIOD
module dynamic_stepper
    import dynamic_stepper_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned STEP_HIGH       = 2,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16
) (
    input  logic dyn_clk,
    input  logic reset_n,
    input  logic btn_up,
    input  logic btn_down,
    output logic inc,
    output logic dec,
    output logic busy,
    output logic repeating
);

    localparam int unsigned TW = timer_width(DEBOUNCE_CYCLES, STEP_HIGH, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [TW-1:0] SH_LAST = TW'(STEP_HIGH - 1);
    localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);

    logic          up_lvl, up_rise, dn_lvl, dn_rise;
    state_t        state_q, state_d;
    dir_t          dir_q, dir_d;
    logic          rep_q, rep_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          held;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk_i   (dyn_clk),
        .rst_ni  (reset_n),
        .btn_i   (btn_up),
        .level_o (up_lvl),
        .rise_o  (up_rise)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk_i   (dyn_clk),
        .rst_ni  (reset_n),
        .btn_i   (btn_down),
        .level_o (dn_lvl),
        .rise_o  (dn_rise)
    );

    assign held = (dir_q == DIR_UP) ? up_lvl : dn_lvl;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rep_d   = rep_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_IDLE: begin
                rep_d = 1'b0;
                // A rise while the other button is at all high is a conflict.
                if (up_rise && !dn_lvl) begin
                    state_d = ST_PULSE;
                    dir_d   = DIR_UP;
                    tmr_d   = SH_LAST;
                end else if (dn_rise && !up_lvl) begin
                    state_d = ST_PULSE;
                    dir_d   = DIR_DOWN;
                    tmr_d   = SH_LAST;
                end
            end
            ST_PULSE: begin
                if (tmr_q == '0) begin
                    state_d = ST_WAIT;
                    tmr_d   = rep_q ? RP_LAST : RD_LAST;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (!held) begin
                    state_d = ST_IDLE;
                    rep_d   = 1'b0;
                    tmr_d   = '0;
                end else if (tmr_q == '0) begin
                    state_d = ST_PULSE;
                    rep_d   = 1'b1;
                    tmr_d   = SH_LAST;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rep_d   = 1'b0;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge dyn_clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            rep_q   <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rep_q   <= rep_d;
            tmr_q   <= tmr_d;
        end
    end

    assign inc       = (state_q == ST_PULSE) && (dir_q == DIR_UP);
    assign dec       = (state_q == ST_PULSE) && (dir_q == DIR_DOWN);
    assign busy      = (state_q != ST_IDLE);
    assign repeating = rep_q;

endmodule

// File: tb/tb_dynamic_stepper.sv
// Directed bench: expected pulses are queued by the stimulus, a monitor pops and compares them.
module tb_dynamic_stepper;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic inc, dec, busy, repeating;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int t0 = 0;

    typedef struct {
        int start;
        int dir;
        int rep;
        int width;
    } exp_t;

    exp_t exp_q[$];

    dynamic_stepper #(
        .DEBOUNCE_CYCLES(4),
        .STEP_HIGH(2),
        .REPEAT_DELAY(8),
        .REPEAT_PERIOD(4)
    ) dut (
        .dyn_clk   (clk),
        .reset_n   (reset_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .inc       (inc),
        .dec       (dec),
        .busy      (busy),
        .repeating (repeating)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic push(input int start, input int dir, input int rep, input int width);
        exp_t e;
        e.start = start;
        e.dir   = dir;
        e.rep   = rep;
        e.width = width;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg(input int c);
        goto(c);
        @(negedge clk);
    endtask

    task automatic start_test();
        @(posedge clk);
        #1;
        t0 = cyc;
    endtask

    task automatic expect_drained(input string name);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: measure each inc/dec pulse and compare it to the next queued one.
    int  act_on = 0;
    int  act_start = 0;
    int  act_dir = 0;
    int  act_rep = 0;
    int  act_w = 0;

    always @(negedge clk) begin
        exp_t e;
        chk("inc_dec_exclusive", int'(inc && dec), 0);
        if ((inc || dec) && act_on == 0) begin
            act_on    = 1;
            act_start = cyc;
            act_dir   = int'(dec);
            act_rep   = int'(repeating);
            act_w     = 1;
        end else if ((inc || dec) && act_on == 1) begin
            act_w++;
        end else if (!(inc || dec) && act_on == 1) begin
            act_on = 0;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got pulse dir %0d at cycle %0d, required none",
                         act_dir, act_start);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_start", act_start, e.start);
                chk("pulse_dir", act_dir, e.dir);
                chk("pulse_repeating", act_rep, e.rep);
                chk("pulse_width", act_w, e.width);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_inc", int'(inc), 0);
        chk("reset_dec", int'(dec), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_repeating", int'(repeating), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        goto(cyc + 12);

        // Single short tap
        start_test();
        push(t0 + 7, 0, 0, 2);
        btn_up = 1'b1;
        goto(t0 + 6); btn_up = 1'b0;
        at_neg(t0 + 10); chk("tap_busy_wait", int'(busy), 1);
        at_neg(t0 + 14); chk("tap_busy_idle", int'(busy), 0);
        at_neg(t0 + 40); expect_drained("tap_pending");

        // Held down button auto-repeats
        start_test();
        push(t0 + 7, 1, 0, 2);
        for (int k = 0; k < 9; k++) push(t0 + 17 + 6 * k, 1, 1, 2);
        btn_down = 1'b1;
        at_neg(t0 + 16); chk("hold_rep_before", int'(repeating), 0);
        at_neg(t0 + 17); chk("hold_rep_after", int'(repeating), 1);
        goto(t0 + 60); btn_down = 1'b0;
        at_neg(t0 + 80);
        chk("hold_rep_cleared", int'(repeating), 0);
        chk("hold_busy_idle", int'(busy), 0);
        expect_drained("hold_pending");

        // Bouncing contact never accepted
        start_test();
        for (int k = 0; k < 10; k++) begin
            goto(t0 + 2 * k);
            btn_up = ((k % 2) == 0);
        end
        goto(t0 + 20); btn_up = 1'b0;
        at_neg(t0 + 24); chk("bounce_busy", int'(busy), 0);
        at_neg(t0 + 40); expect_drained("bounce_pending");

        // Both pressed together
        start_test();
        btn_up = 1'b1; btn_down = 1'b1;
        at_neg(t0 + 10); chk("both_busy", int'(busy), 0);
        goto(t0 + 40); btn_up = 1'b0; btn_down = 1'b0;
        at_neg(t0 + 60); expect_drained("both_pending");

        // Opposite button while up is latched, still held after up releases
        start_test();
        push(t0 + 7, 0, 0, 2);
        push(t0 + 17, 0, 1, 2);
        push(t0 + 23, 0, 1, 2);
        push(t0 + 29, 0, 1, 2);
        btn_up = 1'b1;
        goto(t0 + 12); btn_down = 1'b1;
        goto(t0 + 25); btn_up = 1'b0;
        at_neg(t0 + 33); chk("conflict_busy_idle", int'(busy), 0);
        goto(t0 + 40); btn_down = 1'b0;
        at_neg(t0 + 70); expect_drained("conflict_pending");

        // Release just early enough to cancel the repeat
        start_test();
        push(t0 + 7, 0, 0, 2);
        btn_up = 1'b1;
        goto(t0 + 10); btn_up = 1'b0;
        at_neg(t0 + 16); chk("rel_busy_last_wait", int'(busy), 1);
        at_neg(t0 + 17); chk("rel_busy_idle", int'(busy), 0);
        at_neg(t0 + 40); expect_drained("rel_pending");

        // Release one cycle later: the first repeat still fires
        start_test();
        push(t0 + 7, 0, 0, 2);
        push(t0 + 17, 0, 1, 2);
        btn_up = 1'b1;
        goto(t0 + 11); btn_up = 1'b0;
        at_neg(t0 + 19); chk("rel_late_busy", int'(busy), 1);
        at_neg(t0 + 20); chk("rel_late_idle", int'(busy), 0);
        at_neg(t0 + 40); expect_drained("rel_late_pending");

        // Reset during a pulse; a held button must be released before it counts
        start_test();
        push(t0 + 7, 0, 0, 1);
        btn_up = 1'b1;
        at_neg(t0 + 7); chk("rst_inc_high", int'(inc), 1);
        reset_n = 1'b0;
        at_neg(t0 + 8);
        chk("rst_inc_low", int'(inc), 0);
        chk("rst_busy_low", int'(busy), 0);
        goto(t0 + 10); reset_n = 1'b1;
        at_neg(t0 + 30); chk("rst_held_busy", int'(busy), 0);
        goto(t0 + 40); btn_up = 1'b0;
        goto(t0 + 60);
        push(t0 + 67, 0, 0, 2);
        btn_up = 1'b1;
        goto(t0 + 66); btn_up = 1'b0;
        at_neg(t0 + 100); expect_drained("rst_pending");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
